// File: rtl/oam_dma.sv
// OAM DMA engine: a write to IO register 7'h46 copies 160 bytes from {src_eff, 8'h00..8'h9F}
// into OAM at one byte every 4 clocks. Build macro OAM_DMA_ECHO_MAP_EN folds echo-RAM sources.
module oam_dma (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [6:0]  ctrl_addr,
   input  logic        ctrl_enable,
   input  logic        ctrl_write,
   input  logic [7:0]  ctrl_data_in,
   output logic [7:0]  ctrl_data_out,
   output logic [15:0] bus_addr,
   output logic        bus_read,
   input  logic [7:0]  bus_data_in,
   output logic [7:0]  oam_addr,
   output logic        oam_enable,
   output logic        oam_write,
   output logic [7:0]  oam_data_out,
   output logic        active
);

   localparam logic [6:0] DMA_REG_ADDR = 7'h46;
   localparam logic [7:0] LAST_INDEX   = 8'd159;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_XFER  = 2'd2
   } state_t;

   // Complete sequencer state in one struct so checkers can bind to a single signal.
   typedef struct packed {
      state_t     state;
      logic [1:0] phase;
      logic [7:0] index;
   } fsm_t;

   fsm_t        fsm_q, fsm_d;
   logic [7:0]  src_q, src_d;
   logic [7:0]  ctrl_data_out_q, ctrl_data_out_d;
   logic [15:0] bus_addr_q, bus_addr_d;
   logic        bus_read_q, bus_read_d;
   logic [7:0]  oam_addr_q, oam_addr_d;
   logic        oam_enable_q, oam_enable_d;
   logic        oam_write_q, oam_write_d;
   logic [7:0]  oam_data_q, oam_data_d;
   logic        active_q, active_d;

   logic        trigger;
   logic        reg_read;
   logic [7:0]  src_eff;

`ifdef OAM_DMA_ECHO_MAP_EN
   assign src_eff = (src_q >= 8'hE0) ? (src_q - 8'h20) : src_q;
`else
   assign src_eff = src_q;
`endif

   always_comb begin
      trigger  = ctrl_enable && ctrl_write && (ctrl_addr == DMA_REG_ADDR);
      reg_read = ctrl_enable && !ctrl_write && (ctrl_addr == DMA_REG_ADDR);
   end

   // Sequencer: START burns 4 clocks, then each slot walks phases 0..3.
   always_comb begin
      fsm_d = fsm_q;
      if (trigger) begin
         fsm_d.state = ST_START;
         fsm_d.phase = 2'd0;
         fsm_d.index = 8'd0;
      end else begin
         case (fsm_q.state)
            ST_IDLE: begin
               fsm_d = fsm_q;
            end
            ST_START: begin
               fsm_d.phase = fsm_q.phase + 2'd1;
               if (fsm_q.phase == 2'd3) begin
                  fsm_d.state = ST_XFER;
                  fsm_d.index = 8'd0;
               end
            end
            ST_XFER: begin
               fsm_d.phase = fsm_q.phase + 2'd1;
               if (fsm_q.phase == 2'd3) begin
                  if (fsm_q.index == LAST_INDEX) begin
                     fsm_d.state = ST_IDLE;
                     fsm_d.index = 8'd0;
                  end else begin
                     fsm_d.index = fsm_q.index + 8'd1;
                  end
               end
            end
            default: begin
               fsm_d.state = ST_IDLE;
               fsm_d.phase = 2'd0;
               fsm_d.index = 8'd0;
            end
         endcase
      end
   end

   // Outputs are registered from the next state so each strobe lines up with its phase cycle.
   always_comb begin
      src_d           = trigger ? ctrl_data_in : src_q;
      ctrl_data_out_d = reg_read ? src_q : ctrl_data_out_q;

      bus_read_d = (fsm_d.state == ST_XFER) && (fsm_d.phase == 2'd0);
      bus_addr_d = bus_read_d ? {src_eff, fsm_d.index} : bus_addr_q;

      oam_enable_d = (fsm_d.state == ST_XFER) && (fsm_d.phase == 2'd2);
      oam_write_d  = oam_enable_d;
      oam_addr_d   = oam_enable_d ? fsm_d.index : oam_addr_q;

      // Source byte arrives the cycle after bus_read; grab it at the end of phase 1.
      oam_data_d = ((fsm_q.state == ST_XFER) && (fsm_q.phase == 2'd1)) ? bus_data_in : oam_data_q;

      active_d = (fsm_d.state != ST_IDLE);
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         fsm_q.state     <= ST_IDLE;
         fsm_q.phase     <= 2'd0;
         fsm_q.index     <= 8'd0;
         src_q           <= 8'h00;
         ctrl_data_out_q <= 8'h00;
         bus_addr_q      <= 16'h0000;
         bus_read_q      <= 1'b0;
         oam_addr_q      <= 8'h00;
         oam_enable_q    <= 1'b0;
         oam_write_q     <= 1'b0;
         oam_data_q      <= 8'h00;
         active_q        <= 1'b0;
      end else begin
         fsm_q           <= fsm_d;
         src_q           <= src_d;
         ctrl_data_out_q <= ctrl_data_out_d;
         bus_addr_q      <= bus_addr_d;
         bus_read_q      <= bus_read_d;
         oam_addr_q      <= oam_addr_d;
         oam_enable_q    <= oam_enable_d;
         oam_write_q     <= oam_write_d;
         oam_data_q      <= oam_data_d;
         active_q        <= active_d;
      end
   end

   assign ctrl_data_out = ctrl_data_out_q;
   assign bus_addr      = bus_addr_q;
   assign bus_read      = bus_read_q;
   assign oam_addr      = oam_addr_q;
   assign oam_enable    = oam_enable_q;
   assign oam_write     = oam_write_q;
   assign oam_data_out  = oam_data_q;
   assign active        = active_q;

endmodule

// File: tb/tb_oam_dma.sv
// Bench for oam_dma: a cycle-number model of the transfer checks every output each cycle,
// and directed scenarios pin the model with hand-computed literals.
module tb_oam_dma;

   logic        clk;
   logic        reset_n;
   logic [6:0]  ctrl_addr;
   logic        ctrl_enable;
   logic        ctrl_write;
   logic [7:0]  ctrl_data_in;
   logic [7:0]  ctrl_data_out;
   logic [15:0] bus_addr;
   logic        bus_read;
   logic [7:0]  bus_data_in;
   logic [7:0]  oam_addr;
   logic        oam_enable;
   logic        oam_write;
   logic [7:0]  oam_data_out;
   logic        active;

   oam_dma dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .ctrl_addr     (ctrl_addr),
      .ctrl_enable   (ctrl_enable),
      .ctrl_write    (ctrl_write),
      .ctrl_data_in  (ctrl_data_in),
      .ctrl_data_out (ctrl_data_out),
      .bus_addr      (bus_addr),
      .bus_read      (bus_read),
      .bus_data_in   (bus_data_in),
      .oam_addr      (oam_addr),
      .oam_enable    (oam_enable),
      .oam_write     (oam_write),
      .oam_data_out  (oam_data_out),
      .active        (active)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- bus responder ----------------
   bit          mix = 1'b0;
   logic        pend_rd;
   logic [15:0] pend_addr;

   function automatic logic [7:0] bus_fn(input logic [15:0] a);
      return mix ? (a[7:0] ^ a[15:8]) : a[7:0];
   endfunction

   always @(negedge clk) begin
      pend_rd   = bus_read;
      pend_addr = bus_addr;
   end

   always @(posedge clk) begin
      #1;
      bus_data_in = pend_rd ? bus_fn(pend_addr) : 8'h00;
   end

   // ---------------- behavioural model ----------------
   function automatic logic [7:0] eff(input logic [7:0] s);
`ifdef OAM_DMA_ECHO_MAP_EN
      return (s >= 8'hE0) ? (s - 8'h20) : s;
`else
      return s;
`endif
   endfunction

   bit          model_on = 1'b0;
   bit          have     = 1'b0;
   int          cyc      = 0;
   int          e0       = 0;
   logic [7:0]  m_src    = 8'h00;
   logic [7:0]  m_cdo    = 8'h00;
   logic [15:0] m_bus_addr = 16'h0000;
   logic [7:0]  m_oam_addr = 8'h00;

   // Model update: inputs are stable at the edge, so sample them directly.
   always @(posedge clk) begin
      cyc++;
      if (!reset_n) begin
         model_on   = 1'b1;
         have       = 1'b0;
         m_src      = 8'h00;
         m_cdo      = 8'h00;
         m_bus_addr = 16'h0000;
         m_oam_addr = 8'h00;
      end else if (ctrl_enable && ctrl_addr == 7'h46) begin
         if (ctrl_write) begin
            have  = 1'b1;
            e0    = cyc;
            m_src = ctrl_data_in;
         end else begin
            m_cdo = m_src;
         end
      end
   end

   // ---------------- statistics + per-cycle compare ----------------
   int          oam_writes, active_cycles, inactive_cycles, early_strobes;
   int          first_rd_n, first_wr_n;
   bit          first_rd_seen, first_wr_seen;
   logic [15:0] first_rd_addr;
   logic [7:0]  first_wr_addr, first_wr_data, last_wr_addr, last_wr_data;

   task automatic clear_stats();
      oam_writes      = 0;
      active_cycles   = 0;
      inactive_cycles = 0;
      early_strobes   = 0;
      first_rd_seen   = 1'b0;
      first_wr_seen   = 1'b0;
      first_rd_n      = -1;
      first_wr_n      = -1;
      first_rd_addr   = 16'hFFFF;
      first_wr_addr   = 8'hFF;
      first_wr_data   = 8'hFF;
      last_wr_addr    = 8'hFF;
      last_wr_data    = 8'hFF;
   endtask

   always @(negedge clk) begin
      int   n, k, ph;
      bit   x_active, x_rd, x_wr;
      logic [7:0] x_data;
      if (model_on) begin
         n        = cyc - e0 + 1;
         x_active = have && (n >= 1) && (n <= 644);
         k        = (n - 5) / 4;
         ph       = (n - 5) % 4;
         x_rd     = x_active && (n >= 5) && (ph == 0);
         x_wr     = x_active && (n >= 5) && (ph == 2);
         x_data   = 8'h00;
         if (x_rd) m_bus_addr = {eff(m_src), k[7:0]};
         if (x_wr) begin
            m_oam_addr = k[7:0];
            x_data     = bus_fn({eff(m_src), k[7:0]});
         end
         check("active", active, x_active);
         check("bus_read", bus_read, x_rd);
         check("bus_addr", bus_addr, m_bus_addr);
         check("oam_enable", oam_enable, x_wr);
         check("oam_write", oam_write, x_wr);
         check("oam_addr", oam_addr, m_oam_addr);
         if (x_wr) check("oam_data_out", oam_data_out, x_data);
         check("ctrl_data_out", ctrl_data_out, m_cdo);

         if (active) active_cycles++; else inactive_cycles++;
         if (have && n >= 1 && n <= 4 && (bus_read || oam_enable || oam_write)) early_strobes++;
         if (bus_read && !first_rd_seen) begin
            first_rd_seen = 1'b1;
            first_rd_n    = n;
            first_rd_addr = bus_addr;
         end
         if (oam_enable && oam_write) begin
            oam_writes++;
            if (!first_wr_seen) begin
               first_wr_seen = 1'b1;
               first_wr_n    = n;
               first_wr_addr = oam_addr;
               first_wr_data = oam_data_out;
            end
            last_wr_addr = oam_addr;
            last_wr_data = oam_data_out;
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic cycle();
      @(posedge clk);
      #2;
   endtask

   task automatic io_write(input logic [6:0] a, input logic [7:0] d);
      ctrl_addr    = a;
      ctrl_data_in = d;
      ctrl_enable  = 1'b1;
      ctrl_write   = 1'b1;
      cycle();
      ctrl_enable  = 1'b0;
      ctrl_write   = 1'b0;
      ctrl_data_in = 8'h00;
   endtask

   task automatic io_read(input logic [6:0] a);
      ctrl_addr   = a;
      ctrl_enable = 1'b1;
      ctrl_write  = 1'b0;
      cycle();
      ctrl_enable = 1'b0;
   endtask

   task automatic wait_idle(input int budget);
      for (int i = 0; i < budget && active !== 1'b0; i++) cycle();
      check("idle_timeout", active, 1'b0);
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_active"}, active, 1'b0);
      check({tag, "_bus_read"}, bus_read, 1'b0);
      check({tag, "_bus_addr"}, bus_addr, 16'h0000);
      check({tag, "_oam_enable"}, oam_enable, 1'b0);
      check({tag, "_oam_write"}, oam_write, 1'b0);
      check({tag, "_oam_addr"}, oam_addr, 8'h00);
      check({tag, "_oam_data"}, oam_data_out, 8'h00);
      check({tag, "_ctrl_data_out"}, ctrl_data_out, 8'h00);
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #2_000_000;
      failures++;
      $display("FAIL watchdog simulation did not finish actual=running required=done");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // ---------------- directed scenarios ----------------
   initial begin
      reset_n      = 1'b0;
      ctrl_addr    = 7'h00;
      ctrl_enable  = 1'b0;
      ctrl_write   = 1'b0;
      ctrl_data_in = 8'h00;
      bus_data_in  = 8'h00;
      clear_stats();
      repeat (3) cycle();
      reset_n = 1'b1;
      check_reset_values("por");

      // Basic transfer from page C1, data = low address byte.
      mix = 1'b0;
      io_write(7'h46, 8'hC1);
      clear_stats();
      wait_idle(700);
      check("basic_writes", oam_writes, 160);
      check("basic_active_cycles", active_cycles, 644);
      check("basic_first_rd_n", first_rd_n, 5);
      check("basic_first_rd_addr", first_rd_addr, 16'hC100);
      check("basic_first_wr_n", first_wr_n, 7);
      check("basic_first_wr_addr", first_wr_addr, 8'h00);
      check("basic_first_wr_data", first_wr_data, 8'h00);
      check("basic_last_wr_addr", last_wr_addr, 8'h9F);
      check("basic_last_wr_data", last_wr_data, 8'h9F);
      check("basic_early_strobes", early_strobes, 0);

      // Decode: foreign write and reads during XFER.
      mix = 1'b1;
      io_write(7'h46, 8'hC2);
      clear_stats();
      repeat (40) cycle();
      io_write(7'h47, 8'h13);
      io_read(7'h45);
      check("decode_other_read", ctrl_data_out, 8'h00);
      io_read(7'h46);
      check("decode_read_src", ctrl_data_out, 8'hC2);
      wait_idle(700);
      check("decode_writes", oam_writes, 160);
      check("decode_active_cycles", active_cycles, 644);
      check("decode_last_wr_data", last_wr_data, 8'h9F ^ 8'hC2);

      // Restart: second trigger lands at the end of cycle 99.
      io_write(7'h46, 8'hC0);
      clear_stats();
      repeat (98) cycle();
      io_write(7'h46, 8'hD0);
      check("restart_old_writes", oam_writes, 24);
      check("restart_no_gap", inactive_cycles, 0);
      clear_stats();
      wait_idle(700);
      check("restart_first_rd_n", first_rd_n, 5);
      check("restart_first_rd_addr", first_rd_addr, 16'hD000);
      check("restart_first_wr_addr", first_wr_addr, 8'h00);
      check("restart_first_wr_data", first_wr_data, 8'hD0);
      check("restart_writes", oam_writes, 160);
      check("restart_active_cycles", active_cycles, 644);

      // Echo mapping.
      io_write(7'h46, 8'hE3);
      clear_stats();
      repeat (6) cycle();
`ifdef OAM_DMA_ECHO_MAP_EN
      check("echo_first_rd_addr", first_rd_addr, 16'hC300);
`else
      check("echo_first_rd_addr", first_rd_addr, 16'hE300);
`endif
      io_read(7'h46);
      check("echo_read_src", ctrl_data_out, 8'hE3);
      wait_idle(700);
      check("echo_writes", oam_writes, 160);

      // Reset at slot 50 phase 0, with a simultaneous trigger that must be ignored.
      io_write(7'h46, 8'hC4);
      clear_stats();
      repeat (204) cycle();
      check("midreset_writes_before", oam_writes, 50);
      reset_n      = 1'b0;
      ctrl_addr    = 7'h46;
      ctrl_data_in = 8'hAA;
      ctrl_enable  = 1'b1;
      ctrl_write   = 1'b1;
      cycle();
      reset_n      = 1'b1;
      ctrl_enable  = 1'b0;
      ctrl_write   = 1'b0;
      clear_stats();
      check_reset_values("midreset");
      repeat (30) cycle();
      check("midreset_writes_after", oam_writes, 0);
      check("midreset_active_after", active_cycles, 0);
      io_read(7'h46);
      check("midreset_src_cleared", ctrl_data_out, 8'h00);
      io_write(7'h46, 8'hC5);
      clear_stats();
      wait_idle(700);
      check("post_reset_writes", oam_writes, 160);
      check("post_reset_first_rd_addr", first_rd_addr, 16'hC500);
      check("post_reset_last_wr_addr", last_wr_addr, 8'h9F);

      repeat (3) cycle();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/oam_dma.md
OAM_DMA -- requirements
Module: oam_dma

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset, with all state updating on the rising edge of clk.
REQ-002 Port `clk`, input, 1 bit: 4 MHz system clock.
REQ-003 Port `reset_n`, input, 1 bit: synchronous reset, active low.
REQ-004 Port `ctrl_addr`, input, 7 bits: IO register select; the DMA register is 7'h46.
REQ-005 Port `ctrl_enable`, input, 1 bit: IO access strobe.
REQ-006 Port `ctrl_write`, input, 1 bit: IO write enable.
REQ-007 Port `ctrl_data_in`, input, 8 bits: IO write data.
REQ-008 Port `ctrl_data_out`, output, 8 bits: IO read data, registered.
REQ-009 Port `bus_addr`, output, 16 bits: source address presented to the system bus.
REQ-010 Port `bus_read`, output, 1 bit: source read strobe.
REQ-011 Port `bus_data_in`, input, 8 bits: source data, valid the cycle after `bus_read`.
REQ-012 Port `oam_addr`, output, 8 bits: OAM destination index, connected to the PPU OAM port.
REQ-013 Port `oam_enable`, output, 1 bit: OAM access strobe.
REQ-014 Port `oam_write`, output, 1 bit: OAM write enable.
REQ-015 Port `oam_data_out`, output, 8 bits: data to the PPU `oam_data_in`.
REQ-016 Port `active`, output, 1 bit: transfer in progress; CPU bus arbitration uses it to block CPU access.

Function
REQ-017 A DMA trigger is defined as `ctrl_enable` && `ctrl_write` && `ctrl_addr`==7'h46 sampled at an edge, called E0; the SHALL-level effects of a trigger are:
- `ctrl_data_in` is latched as the source high byte `src`;
- the byte index is cleared to 0;
- the state enters START.
REQ-018 The state machine SHALL have states IDLE, START and XFER, with a 2-bit phase counter and an 8-bit index counter (0..159).
REQ-019 Cycle numbering: cycle n is the n-th clock period after E0.
- START occupies cycles 1-4.
- Slot k (k = 0..159) occupies cycles 5+4k to 8+4k.
REQ-020 Phase 0 of slot k SHALL assert `bus_read`=1 with `bus_addr`={src_eff, k}; `bus_read`=0 in all other cycles.
REQ-021 Phase 1 of slot k SHALL capture `bus_data_in` into the data register at the end of that cycle.
REQ-022 Phase 2 of slot k SHALL assert `oam_enable`=1 and `oam_write`=1, with `oam_addr`=k and `oam_data_out`=captured byte; both strobes SHALL be 0 in every other cycle.
REQ-023 Phase 3 is idle; after phase 3 of slot 159 (cycle 644) the state SHALL return to IDLE.
REQ-024 `active` SHALL be 1 in cycles 1-644 inclusive and 0 from cycle 645 onward; the total transfer latency is 644 clocks.
REQ-025 A trigger while START or XFER SHALL abort the current transfer immediately, latch the new `src`, and restart at START with a new E0. `active` stays 1 with no gap, and no OAM write of the old transfer occurs after the new E0.
REQ-026 A read (`ctrl_enable` && !`ctrl_write` && `ctrl_addr`==7'h46) SHALL load `ctrl_data_out` with the last written `src` on the next edge.
- Reads to other addresses leave `ctrl_data_out` unchanged.
- Reads are legal in any state and do not disturb the transfer.
REQ-027 Writes to other `ctrl_addr` values SHALL be ignored.
REQ-028 `bus_addr` and `oam_addr` SHALL hold their last value when the block is idle; only the strobes qualify them.

Reset
REQ-029 When `reset_n`=0 at an edge, the block SHALL set the following at the next edge, regardless of state:
- state = IDLE, phase = 0, index = 0;
- `src` = 8'h00, `ctrl_data_out` = 8'h00;
- `bus_addr` = 16'h0000, `bus_read` = 0;
- `oam_addr` = 0, `oam_enable` = 0, `oam_write` = 0, `oam_data_out` = 0;
- `active` = 0.
REQ-030 Reset during START or XFER SHALL abandon the transfer with no further strobes, and a trigger in the same cycle as reset SHALL be ignored.

Configuration
REQ-031 With macro `OAM_DMA_ECHO_MAP_EN` defined:
- src_eff = `src` - 8'h20 when `src` >= 8'hE0 (echo RAM maps to 8'hC0-8'hDF);
- otherwise src_eff = `src`.
REQ-032 Without `OAM_DMA_ECHO_MAP_EN`, src_eff = `src` for all values. In both cases `ctrl_data_out` returns the unmapped `src`.

Verification
REQ-033 Basic transfer: write 8'hC1 to 7'h46, with the bus model returning the low address byte.
- Expect 160 OAM writes with `oam_addr`=k and data=k.
- First `bus_addr`=16'hC100 in cycle 5.
- `active` deasserts at cycle 645.
REQ-034 Strobe timing: for slot 0, check `bus_read` only in cycle 5, data captured in cycle 6, `oam_write` only in cycle 7, and nothing in cycles 1-4 or 8.
REQ-035 Restart: write 8'hC0, then write 8'hD0 at cycle 100.
- `active` stays 1 throughout.
- Next `bus_read` has `bus_addr`=16'hD000, 5 cycles after the second write.
- 160 further OAM writes occur starting at index 0.
REQ-036 Echo map: write 8'hE3.
- With `OAM_DMA_ECHO_MAP_EN`, first `bus_addr`=16'hC300.
- Without it, first `bus_addr`=16'hE300.
- A read of 7'h46 returns 8'hE3 in both builds.
REQ-037 Reset mid-transfer: assert `reset_n`=0 at slot 50.
- All outputs reach their reset values next cycle.
- No OAM write occurs afterward.
- A subsequent trigger performs a full 160-byte transfer.
REQ-038 Decode: a write to 7'h47 and a read of 7'h46 during XFER cause no trigger and no transfer disturbance, and the read returns `src`.
